// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin core/debug arbiter onto a byte-wide data memory
module dmem_arbiter #(
  parameter int ADDR_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [1:0]        core_size,
  input  logic              core_unsigned,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [31:0]       core_wdata,
  output logic              core_done,
  output logic [31:0]       core_rdata,
  output logic              core_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [7:0]        dbg_wdata,
  output logic [7:0]        dbg_rdata,
  output logic              dbg_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic              mem_re,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);
  typedef enum logic [1:0] {IDLE, CORE_BEAT, DBG_BEAT, RESP} state_t;
  state_t            state_q, state_d;
  logic [1:0]        beat_q, beat_d, size_q, size_d;
  logic              last_dbg_q, last_dbg_d, gnt_dbg_q, gnt_dbg_d;
  logic              we_q, we_d, uns_q, uns_d, pick_dbg, in_beat;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d, buf_q, buf_d, ext;
  logic [1:0]        last_beat;
  assign in_beat   = (state_q == CORE_BEAT) || (state_q == DBG_BEAT);
  assign last_beat = size_q == 2'd0 ? 2'd0 : size_q == 2'd1 ? 2'd1 : 2'd3;
  // Debug only wins a tie when the core won the previous tie; otherwise whoever asks alone
  assign pick_dbg  = dbg_req & (~core_req | ~last_dbg_q);
  // Next-state: latch the winning request in IDLE, step one byte per beat, one response cycle
  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    size_d     = size_q;
    last_dbg_d = last_dbg_q;
    gnt_dbg_d  = gnt_dbg_q;
    we_d       = we_q;
    uns_d      = uns_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    buf_d      = buf_q;
    case (state_q)
      IDLE: if (core_req || dbg_req) begin
        last_dbg_d = (core_req && dbg_req) ? pick_dbg : last_dbg_q;
        gnt_dbg_d  = pick_dbg;
        we_d       = pick_dbg ? dbg_we : core_we;
        size_d     = pick_dbg ? 2'd0 : core_size;
        uns_d      = core_unsigned;
        addr_d     = pick_dbg ? dbg_addr : core_addr;
        wdata_d    = pick_dbg ? {24'h0, dbg_wdata} : core_wdata;
        beat_d     = 2'd0;
        buf_d      = 32'h0;
        state_d    = pick_dbg ? DBG_BEAT : CORE_BEAT;
      end
      CORE_BEAT, DBG_BEAT: begin
        if (!we_q) buf_d[{beat_q, 3'b000} +: 8] = mem_rdata;
        beat_d  = beat_q + 2'd1;
        state_d = beat_q == last_beat ? RESP : state_q;
      end
      default: state_d = IDLE;
    endcase
  end
  // State register; reset abandons any access without a completion pulse
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      beat_q     <= 2'd0;
      size_q     <= 2'd0;
      last_dbg_q <= 1'b1;
      gnt_dbg_q  <= 1'b0;
      we_q       <= 1'b0;
      uns_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= 32'h0;
      buf_q      <= 32'h0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      size_q     <= size_d;
      last_dbg_q <= last_dbg_d;
      gnt_dbg_q  <= gnt_dbg_d;
      we_q       <= we_d;
      uns_q      <= uns_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      buf_q      <= buf_d;
    end
  end
  // Extend the captured bytes from the top bit of the requested size
  always_comb begin
    ext = size_q == 2'd0 ? {{24{~uns_q & buf_q[7]}}, buf_q[7:0]} :
          size_q == 2'd1 ? {{16{~uns_q & buf_q[15]}}, buf_q[15:0]} : buf_q;
  end
  assign mem_addr   = in_beat ? addr_q + ADDR_W'(beat_q) : '0;
  assign mem_we     = in_beat & we_q;
  assign mem_re     = in_beat & ~we_q;
  assign mem_wdata  = in_beat ? wdata_q[{beat_q, 3'b000} +: 8] : 8'h0;
  assign core_done  = (state_q == RESP) & ~gnt_dbg_q;
  assign dbg_ack    = (state_q == RESP) & gnt_dbg_q;
  assign core_rdata = (core_done & ~we_q) ? ext : 32'h0;
  assign dbg_rdata  = (dbg_ack & ~we_q) ? buf_q[7:0] : 8'h0;
  assign core_stall = core_req & ~core_done;
endmodule
